// File: rtl/flag_shadow_stack_if.sv
// flag_shadow_stack_if: control/status bundle between the control unit and the flag shadow stack
// Ports (slave view, i.e. the stack):
//   flg_d_i/flg_ld_i/flg_set_i/flg_clr_i  per-flag ALU data, load, force-1, force-0
//   flg_push_i/flg_pop_i                  interrupt entry save / return restore
//   err_clr_i                             clear the sticky error flags
//   flg_q_o                               live flags
//   cnt_o/empty_o/full_o                  stack occupancy and its decodes
//   ovf_o/unf_o                           sticky push-while-full / pop-while-empty
interface flag_shadow_stack_if #(
    parameter int NFLAGS = 2,
    parameter int DEPTH  = 4
);
    localparam int CW = $clog2(DEPTH + 1);
    logic [NFLAGS-1:0] flg_d_i;
    logic [NFLAGS-1:0] flg_ld_i;
    logic [NFLAGS-1:0] flg_set_i;
    logic [NFLAGS-1:0] flg_clr_i;
    logic              flg_push_i;
    logic              flg_pop_i;
    logic              err_clr_i;
    logic [NFLAGS-1:0] flg_q_o;
    logic [CW-1:0]     cnt_o;
    logic              empty_o;
    logic              full_o;
    logic              ovf_o;
    logic              unf_o;
    modport master (
        output flg_d_i, flg_ld_i, flg_set_i, flg_clr_i, flg_push_i, flg_pop_i, err_clr_i,
        input  flg_q_o, cnt_o, empty_o, full_o, ovf_o, unf_o
    );
    modport slave (
        input  flg_d_i, flg_ld_i, flg_set_i, flg_clr_i, flg_push_i, flg_pop_i, err_clr_i,
        output flg_q_o, cnt_o, empty_o, full_o, ovf_o, unf_o
    );
endinterface

// File: rtl/flag_shadow_stack.sv
// flag_shadow_stack: status flag register with a LIFO shadow stack for nested interrupts
// Ports:
//   clk_i  system clock, rising edge
//   rst_i  asynchronous active-high reset (flags, count, errors; stack storage is not cleared)
//   bus    flag_shadow_stack_if slave modport: flag controls, push/pop, error clear, status
module flag_shadow_stack #(
    parameter int NFLAGS = 2,
    parameter int DEPTH  = 4
) (
    input logic             clk_i,
    input logic             rst_i,
    flag_shadow_stack_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    logic [NFLAGS-1:0] stk_q [DEPTH];
    logic [NFLAGS-1:0] flg_q, flg_d, top;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              empty, full, pushv, popv;
    assign empty = cnt_q == '0;
    assign full  = cnt_q == CW'(DEPTH);
    // simultaneous push and pop cancel out entirely
    assign pushv = bus.flg_push_i & ~bus.flg_pop_i & ~full;
    assign popv  = bus.flg_pop_i & ~bus.flg_push_i & ~empty;
    // decoded read of entry[cnt-1]; avoids an out-of-range index when empty
    always_comb begin
        top = '0;
        for (int k = 0; k < DEPTH; k++) if (cnt_q == CW'(k + 1)) top = stk_q[k];
    end
    // priority per bit: clear, set, pop restore, load, hold
    always_comb begin
        flg_d = ~bus.flg_clr_i & (bus.flg_set_i |
                (popv ? top : (bus.flg_ld_i & bus.flg_d_i) | (~bus.flg_ld_i & flg_q)));
        cnt_d = pushv ? cnt_q + CW'(1) : popv ? cnt_q - CW'(1) : cnt_q;
        ovf_d = (ovf_q & ~bus.err_clr_i) | (bus.flg_push_i & ~bus.flg_pop_i & full);
        unf_d = (unf_q & ~bus.err_clr_i) | (bus.flg_pop_i & ~bus.flg_push_i & empty);
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            flg_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            flg_q <= flg_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end
    // storage needs no reset: an entry is only read after it has been written
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < DEPTH; k++) if (pushv && cnt_q == CW'(k)) stk_q[k] <= flg_q;
    end
    assign bus.flg_q_o = flg_q;
    assign bus.cnt_o   = cnt_q;
    assign bus.empty_o = empty;
    assign bus.full_o  = full;
    assign bus.ovf_o   = ovf_q;
    assign bus.unf_o   = unf_q;
endmodule
